// File: rtl/fmt_packer.sv
// fmt_packer: formatter stage that buffers arbitrated words in a FIFO,
// groups them into single-channel packets of length L and emits them framed.
//
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   in_valid/in_chid/in_data/in_ready
//                          upstream word handshake
//   cfg_length             configured packet length (0 -> 1, >DEPTH -> DEPTH)
//   fmt_req/fmt_chid/fmt_length
//                          packet request, channel and effective length
//   fmt_data/fmt_start/fmt_end
//                          packet words with start/end framing
//   fmt_grant              downstream grant, honoured only while requesting
//   fifo_level             current FIFO occupancy (0..DEPTH)

module fmt_packer #(
    parameter int DEPTH = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    input  logic [1:0]               in_chid,
    input  logic [DW-1:0]            in_data,
    output logic                     in_ready,
    input  logic [5:0]               cfg_length,
    output logic                     fmt_req,
    output logic [1:0]               fmt_chid,
    output logic [5:0]               fmt_length,
    output logic [DW-1:0]            fmt_data,
    output logic                     fmt_start,
    output logic                     fmt_end,
    input  logic                     fmt_grant,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t state, state_d;

    logic [DW+1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [LW-1:0]  level;
    logic [LW-1:0]  len;
    logic [LW-1:0]  grp_cnt;
    logic [1:0]     grp_chid;
    logic [LW-1:0]  snd_cnt;

    logic           full;
    logic           wr;
    logic           pop;
    logic [1:0]     head_chid;
    logic [DW-1:0]  head_data;

    logic           req_d;
    logic [1:0]     chid_d;
    logic [5:0]     length_d;
    logic [DW-1:0]  data_d;
    logic           start_d;
    logic           end_d;
    logic [LW-1:0]  snd_d;

    // Effective packet length, clamped to 1..DEPTH
    always_comb begin
        if (cfg_length == 6'd0)
            len = LW'(1);
        else if (32'(cfg_length) > DEPTH)
            len = LW'(DEPTH);
        else
            len = LW'(cfg_length);
    end

    assign full       = (level == LW'(DEPTH));
    assign fifo_level = level;
    assign head_chid  = mem[rd_ptr][DW+1:DW];
    assign head_data  = mem[rd_ptr][DW-1:0];

    // A different channel waits until the open group is complete
    assign in_ready = !full &&
                      ((grp_cnt == '0) || (in_chid == grp_chid));
    assign wr       = in_valid && in_ready;

    // Pop on grant and on every SEND cycle except the one showing the end word
    assign pop = ((state == REQ) && fmt_grant) ||
                 ((state == SEND) && (snd_cnt != len));

    always_ff @(posedge clk) begin
        if (wr)
            mem[wr_ptr] <= {in_chid, in_data};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            grp_cnt  <= '0;
            grp_chid <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (grp_cnt == '0)
                    grp_chid <= in_chid;
                grp_cnt <= (grp_cnt == len - LW'(1)) ?
                           '0 : grp_cnt + LW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({wr, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (level >= len) state_d = REQ;
            REQ:  if (fmt_grant) state_d = SEND;
            SEND: if (snd_cnt == len) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic (next values of the registered fmt_* outputs)
    always_comb begin
        req_d    = fmt_req;
        chid_d   = fmt_chid;
        length_d = fmt_length;
        data_d   = fmt_data;
        start_d  = fmt_start;
        end_d    = fmt_end;
        snd_d    = snd_cnt;
        unique case (state)
            IDLE: begin
                req_d    = 1'b0;
                chid_d   = '0;
                length_d = '0;
                data_d   = '0;
                start_d  = 1'b0;
                end_d    = 1'b0;
                snd_d    = '0;
                if (level >= len) begin
                    req_d    = 1'b1;
                    chid_d   = head_chid;
                    length_d = 6'(len);
                end
            end
            REQ: begin
                if (fmt_grant) begin
                    req_d   = 1'b0;
                    data_d  = head_data;
                    start_d = 1'b1;
                    end_d   = (len == LW'(1));
                    snd_d   = LW'(1);
                end
            end
            SEND: begin
                if (snd_cnt == len) begin
                    req_d    = 1'b0;
                    chid_d   = '0;
                    length_d = '0;
                    data_d   = '0;
                    start_d  = 1'b0;
                    end_d    = 1'b0;
                    snd_d    = '0;
                end else begin
                    data_d  = head_data;
                    start_d = 1'b0;
                    end_d   = ((snd_cnt + LW'(1)) == len);
                    snd_d   = snd_cnt + LW'(1);
                end
            end
            default: begin
                req_d    = 1'b0;
                chid_d   = '0;
                length_d = '0;
                data_d   = '0;
                start_d  = 1'b0;
                end_d    = 1'b0;
                snd_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fmt_req    <= 1'b0;
            fmt_chid   <= '0;
            fmt_length <= '0;
            fmt_data   <= '0;
            fmt_start  <= 1'b0;
            fmt_end    <= 1'b0;
            snd_cnt    <= '0;
        end else begin
            fmt_req    <= req_d;
            fmt_chid   <= chid_d;
            fmt_length <= length_d;
            fmt_data   <= data_d;
            fmt_start  <= start_d;
            fmt_end    <= end_d;
            snd_cnt    <= snd_d;
        end
    end

endmodule

// File: tb/tb_fmt_packer.sv
// tb_fmt_packer: self-checking bench for fmt_packer.
// Expected packet words are queued on accepted writes and popped per output word.

module tb_fmt_packer;

    localparam int DEPTH = 32;
    localparam int DW    = 32;

    logic            clk = 1'b0;
    logic            rstn;
    logic            in_valid;
    logic [1:0]      in_chid;
    logic [DW-1:0]   in_data;
    logic            in_ready;
    logic [5:0]      cfg_length;
    logic            fmt_req;
    logic [1:0]      fmt_chid;
    logic [5:0]      fmt_length;
    logic [DW-1:0]   fmt_data;
    logic            fmt_start;
    logic            fmt_end;
    logic            fmt_grant;
    logic [5:0]      fifo_level;

    fmt_packer #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_chid    (in_chid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .cfg_length (cfg_length),
        .fmt_req    (fmt_req),
        .fmt_chid   (fmt_chid),
        .fmt_length (fmt_length),
        .fmt_data   (fmt_data),
        .fmt_start  (fmt_start),
        .fmt_end    (fmt_end),
        .fmt_grant  (fmt_grant),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] d;
        logic        st;
        logic        en;
        logic [5:0]  len;
    } exp_t;

    exp_t sb[$];
    int   mgrp = 0;
    int   errors = 0;
    int   checks = 0;
    int   mon_words = 0;
    bit   in_pkt = 0;
    bit   prev_end = 0;

    task automatic chk(input string tag,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int eff_len(input logic [5:0] c);
        if (c == 0) return 1;
        if (int'(c) > DEPTH) return DEPTH;
        return int'(c);
    endfunction

    // Output monitor: every framed word is compared against the queue head
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            in_pkt   = 0;
            prev_end = 0;
        end else begin
            if (prev_end)
                chk("post_end", {fmt_req, fmt_start, fmt_end}, 0);
            if (fmt_start || in_pkt) begin
                if (sb.size() == 0) begin
                    chk("extra_word", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("data",   fmt_data,   e.d);
                    chk("start",  fmt_start,  e.st);
                    chk("end",    fmt_end,    e.en);
                    chk("chid",   fmt_chid,   e.ch);
                    chk("length", fmt_length, e.len);
                end
                mon_words++;
                in_pkt = !fmt_end;
            end
            prev_end = fmt_end;
        end
    end

    task automatic put(input logic [1:0] ch, input logic [31:0] d,
                       input int budget, output bit ok, output int tries);
        exp_t e;
        int   l;
        @(negedge clk);
        in_valid = 1'b1;
        in_chid  = ch;
        in_data  = d;
        tries    = 0;
        #1;
        while (!in_ready && tries < budget) begin
            tries++;
            @(negedge clk);
            #1;
        end
        ok = in_ready;
        if (ok) begin
            @(posedge clk);
            l    = eff_len(cfg_length);
            e.ch = ch;
            e.d  = d;
            e.st = (mgrp == 0);
            e.en = (mgrp == l - 1);
            e.len = 6'(l);
            sb.push_back(e);
            mgrp = e.en ? 0 : mgrp + 1;
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic put_ok(input logic [1:0] ch, input logic [31:0] d);
        bit ok;
        int tries;
        put(ch, d, 50, ok, tries);
        chk("put_accept", ok, 1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, sb.size(), 0);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0;
        #1;
        chk({tag, "_req"},   fmt_req,    0);
        chk({tag, "_start"}, fmt_start,  0);
        chk({tag, "_end"},   fmt_end,    0);
        chk({tag, "_data"},  fmt_data,   0);
        chk({tag, "_chid"},  fmt_chid,   0);
        chk({tag, "_len"},   fmt_length, 0);
        chk({tag, "_level"}, fifo_level, 0);
        chk({tag, "_ready"}, in_ready,   1);
        sb.delete();
        mgrp = 0;
        @(negedge clk);
        #3 rstn = 1'b1;
    endtask

    initial begin
        bit ok;
        int tries;
        int acc;
        int n;
        int base;

        rstn       = 1'b0;
        in_valid   = 1'b0;
        in_chid    = '0;
        in_data    = '0;
        fmt_grant  = 1'b0;
        cfg_length = 6'd4;
        repeat (2) @(negedge clk);
        do_reset("rst0");

        // Basic 4-word packet with latency check
        fmt_grant = 1'b1;
        for (int i = 0; i < 4; i++) put_ok(2'd1, 32'h10 + i);
        @(negedge clk);
        chk("lat_pre_req", fmt_req, 0);
        @(negedge clk);
        chk("lat_req",  fmt_req,    1);
        chk("lat_chid", fmt_chid,   1);
        chk("lat_len",  fmt_length, 4);
        drain("drain_t1");

        // Channel change stalls until the open group completes
        put_ok(2'd0, 32'h20);
        put_ok(2'd0, 32'h21);
        @(negedge clk);
        in_valid = 1'b1;
        in_chid  = 2'd2;
        in_data  = 32'h24;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_ch2", in_ready, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        put_ok(2'd0, 32'h22);
        put_ok(2'd0, 32'h23);
        put(2'd2, 32'h24, 0, ok, tries);
        chk("ch2_accept", ok, 1);
        for (int i = 1; i < 4; i++) put_ok(2'd2, 32'h24 + i);
        drain("drain_t2");

        // Single-word packets, cfg_length 1 and 0
        cfg_length = 6'd1;
        put_ok(2'd1, 32'h30);
        put_ok(2'd2, 32'h31);
        put_ok(2'd0, 32'h32);
        drain("drain_l1");
        cfg_length = 6'd0;
        put_ok(2'd3, 32'h40);
        put_ok(2'd3, 32'h41);
        put_ok(2'd1, 32'h42);
        drain("drain_l0");

        // Grant pulse in IDLE ignored, then delayed grant
        cfg_length = 6'd2;
        @(negedge clk);
        fmt_grant = 1'b1;
        @(negedge clk);
        fmt_grant = 1'b0;
        chk("idle_grant_req",   fmt_req,   0);
        chk("idle_grant_start", fmt_start, 0);
        put_ok(2'd2, 32'hA0);
        put_ok(2'd2, 32'hA1);
        n = 0;
        while (!fmt_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("dly_req_seen", fmt_req, 1);
        for (int i = 0; i < 5; i++) begin
            chk("dly_req",  fmt_req,    1);
            chk("dly_chid", fmt_chid,   2);
            chk("dly_len",  fmt_length, 2);
            chk("dly_nostart", fmt_start, 0);
            @(negedge clk);
        end
        fmt_grant = 1'b1;
        drain("drain_dly");

        // Fill to full with grant low, then release
        fmt_grant  = 1'b0;
        cfg_length = 6'd32;
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            put(2'd3, 32'h100 + i, 0, ok, tries);
            if (!ok) break;
            acc++;
        end
        chk("full_accepted", acc, 32);
        chk("full_level", fifo_level, 32);
        @(negedge clk);
        fmt_grant = 1'b1;
        in_valid  = 1'b1;
        #1 chk("full_stall", in_ready, 0);
        put(2'd3, 32'h100 + acc, 3, ok, tries);
        chk("resume_ok", ok, 1);
        chk("resume_tries", tries, 0);
        for (int i = acc + 1; i < 40; i++) put_ok(2'd3, 32'h100 + i);
        n = 0;
        while (sb.size() != 8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("full_sent", sb.size(), 8);
        @(negedge clk);
        do_reset("rst1");

        // Reset in the middle of an 8-word packet
        cfg_length = 6'd8;
        for (int i = 0; i < 8; i++) put_ok(2'd2, 32'h50 + i);
        base = mon_words;
        n = 0;
        while (mon_words < base + 3 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("mid_words", mon_words - base, 3);
        #1;
        do_reset("rst_mid");
        for (int i = 0; i < 8; i++) put_ok(2'd1, 32'h60 + i);
        drain("drain_post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
